// File: rtl/contador_pkg.sv
// Shared mode encodings and Gray helpers
// for the synchronous T-cell counter.
package contador_pkg;

  localparam int MODE_UP   = 0;
  localparam int MODE_DOWN = 1;
  localparam int MODE_GRAY = 2;

  // Widest counter the Gray helpers handle.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Inverse mapping, used to seed the index
  // so a Gray-mode reset shows RST_VAL on q.
  function automatic logic [MAX_W-1:0] gray2bin(
    input logic [MAX_W-1:0] g
  );
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/contador_sync_tff_cell.sv
// One-bit T flip-flop with synchronous
// load of its reset value.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic t,
  output logic q
);

  // Reset wins; otherwise toggle when t is set.
  always_ff @(posedge clk) begin
    if (rst) q <= rst_val;
    else     q <= q ^ t;
  end

endmodule

// File: rtl/contador_sync.sv
// Free-running synchronous counter built
// from per-bit T cells: up, down or Gray.
module contador_sync
  import contador_pkg::*;
#(
  parameter int               WIDTH   = 3,
  parameter int               MODE    = MODE_UP,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam bit IS_DOWN = (MODE == MODE_DOWN);
  localparam bit IS_GRAY = (MODE == MODE_GRAY);

  // The cells hold a binary index; in Gray
  // mode it is the pre-image of RST_VAL.
  localparam logic [WIDTH-1:0] IDX_RST =
    IS_GRAY ? WIDTH'(gray2bin(MAX_W'(RST_VAL)))
            : RST_VAL;

  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] t;

  // Bit i toggles once every lower bit is at
  // its carry (up) or borrow (down) value.
  assign t[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_t
    if (IS_DOWN) begin : g_dn
      assign t[i] = ~|idx[i-1:0];
    end else begin : g_up
      assign t[i] = &idx[i-1:0];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (IDX_RST[i]),
      .t       (t[i]),
      .q       (idx[i])
    );
  end

  // Output mapping and terminal count from
  // registered state only.
  always_comb begin
    q  = idx;
    tc = &idx;
    if (IS_GRAY) begin
      q = WIDTH'(bin2gray(MAX_W'(idx)));
    end
    if (IS_DOWN) begin
      tc = ~|idx;
    end
  end

endmodule

// File: tb/tb_contador_sync.sv
// Bench for contador_sync: up, Gray and
// down instances against a counting model.
module tb_contador_sync;
  import contador_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] q_up, q_gr, q_dn;
  logic       tc_up, tc_gr, tc_dn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  contador_sync #(.WIDTH(3), .MODE(MODE_UP))
  u_up (.clk(clk), .rst(rst), .q(q_up), .tc(tc_up));

  contador_sync #(.WIDTH(3), .MODE(MODE_GRAY))
  u_gr (.clk(clk), .rst(rst), .q(q_gr), .tc(tc_gr));

  contador_sync #(.WIDTH(3), .MODE(MODE_DOWN),
                  .RST_VAL(3'b011))
  u_dn (.clk(clk), .rst(rst), .q(q_dn), .tc(tc_dn));

  task automatic chk(input string nm,
                     input logic [2:0] got,
                     input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b want %b",
               nm, $time, got, exp);
    end
  endtask

  // Behavioural model: plain modular counts.
  int   m_up, m_gi, m_dn;
  bit   valid = 1'b0;
  bit   was_rst;
  logic [2:0] prev_gr;

  always @(posedge clk) begin
    was_rst = rst;
    if (rst) begin
      m_up  = 0;
      m_gi  = 0;
      m_dn  = 3;
      valid = 1'b1;
    end else if (valid) begin
      m_up = (m_up + 1) % 8;
      m_gi = (m_gi + 1) % 8;
      m_dn = (m_dn + 7) % 8;
    end
    #1;
    if (valid) begin
      chk("up_q",  q_up, 3'(m_up));
      chk("up_tc", {2'b0, tc_up}, {2'b0, m_up == 7});
      chk("gr_q",  q_gr, 3'(m_gi ^ (m_gi >> 1)));
      chk("gr_tc", {2'b0, tc_gr}, {2'b0, m_gi == 7});
      chk("dn_q",  q_dn, 3'(m_dn));
      chk("dn_tc", {2'b0, tc_dn}, {2'b0, m_dn == 0});
      if (!was_rst) begin
        chk("gr_1bit", 3'($countones(q_gr ^ prev_gr)),
            3'd1);
      end
      prev_gr = q_gr;
    end
  end

  always @(q_up) begin
    if (valid) $display("t=%0t q=%b", $time, q_up);
  end

  logic [2:0] gr_tab [8];
  logic [2:0] dn_tab [8];
  logic [2:0] snap;
  bit         hit;

  initial begin
    gr_tab = '{3'b001, 3'b011, 3'b010, 3'b110,
               3'b111, 3'b101, 3'b100, 3'b000};
    dn_tab = '{3'b010, 3'b001, 3'b000, 3'b111,
               3'b110, 3'b101, 3'b100, 3'b011};

    // Reset on the first edge.
    @(posedge clk); #1;
    chk("rst_up", q_up, 3'b000);
    chk("rst_gr", q_gr, 3'b000);
    chk("rst_dn", q_dn, 3'b011);
    #4 rst = 1'b0;

    // First eight steps, hand-computed.
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("lit_up", q_up, 3'(k % 8));
      chk("lit_gr", q_gr, gr_tab[k-1]);
      chk("lit_dn", q_dn, dn_tab[k-1]);
      chk("lit_tc_up", {2'b0, tc_up}, {2'b0, k == 7});
      chk("lit_tc_gr", {2'b0, tc_gr}, {2'b0, k == 7});
      chk("lit_tc_dn", {2'b0, tc_dn}, {2'b0, k == 3});
    end

    // Wrap run: twelve more edges (20 total).
    repeat (12) @(posedge clk);
    #1;

    // Reset mid-count once q_up reaches 101.
    hit = 1'b0;
    for (int n = 0; n < 16 && !hit; n++) begin
      if (q_up == 3'b101) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_101: got %b want 101", q_up);
    end
    #4 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_up", q_up, 3'b000);
    chk("mid_rst_dn", q_dn, 3'b011);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_resume_up", q_up, 3'b001);
    chk("mid_resume_dn", q_dn, 3'b010);

    // 2 ns rst glitch that spans no edge.
    snap = q_up;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("glitch_up", q_up, snap + 3'd1);

    repeat (4) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
